switch_word_loader: RTL and testbench

Controller that turns the DE10's ten slide switches and one pushbutton into complete 32-bit words for downstream datapaths, such as a control-word register or a data-input port. It synchronizes and debounces the raw pushbutton and steers `sw[7:0]` into the byte lane chosen by `sw[9:8]` on each debounced press. It tracks which lanes have been loaded and offers the assembled word once all four lanes are present, using a valid/ready handshake. It sits between the board I/O pins and the consumer logic.

---
 rtl/switch_word_loader.sv | 123 ++++++++++++
 tb/tb_switch_word_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_word_loader.sv
// switch_word_loader
// Turns the ten slide switches and one pushbutton into complete 32-bit words.
// sw[9:8] picks a byte lane and sw[7:0] supplies the byte. Each debounced
// press of key_n loads that lane into a shadow register. When all four lanes
// are present, the assembled word is offered downstream.
//
// Handshake: word_valid rises only when a complete word is captured into
// `word`. word and word_valid then hold stable until a transfer, which is a
// rising edge where word_valid && word_ready are both high. word_ready may be
// high before word_valid; the consumer never waits on word_valid to raise it.
module switch_word_loader #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  sw,
    input  logic        key_n,
    output logic [31:0] word,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [3:0]  lane_mask
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        OFFER   = 1'b1
    } state_t;

    logic          key_s1, key_s2;
    logic [9:0]    sw_s1, sw_s2;
    logic          key_db;
    logic [CW-1:0] db_cnt;
    logic          db_fall;
    logic          press;
    logic [31:0]   shadow;
    state_t        state;

    // Two-flop synchronizers for the asynchronous board inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    // The debounced level follows the key only after it has disagreed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_db <= 1'b1;
            db_cnt <= '0;
        end else if (key_s2 != key_db) begin
            if (db_cnt == LAST) begin
                key_db <= key_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // The debounced level is about to fall on this edge.
    assign db_fall = key_db && !key_s2 && (db_cnt == LAST);

    // One-cycle press pulse in the cycle after the debounced level falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press <= 1'b0;
        end else begin
            press <= db_fall;
        end
    end

    // Lane collection and word offer state machine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= COLLECT;
            shadow     <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            lane_mask  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (press) begin
                        shadow[{sw_s2[9:8], 3'b000} +: 8] <= sw_s2[7:0];
                        lane_mask[sw_s2[9:8]]             <= 1'b1;
                    end
                    if (lane_mask == 4'b1111) begin
                        word       <= shadow;
                        word_valid <= 1'b1;
                        state      <= OFFER;
                    end
                end
                OFFER: begin
                    // Presses here are dropped. The shadow stays as is, so a
                    // re-press after the transfer only replaces the lanes it touches.
                    if (word_valid && word_ready) begin
                        word_valid <= 1'b0;
                        lane_mask  <= '0;
                        state      <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_word_loader.sv
// Testbench for switch_word_loader with DEBOUNCE_CYCLES = 4.
// The reference model tracks lanes, the mask and the offered word at the
// level of whole presses and transfers.
module tb_switch_word_loader;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  sw;
    logic        key_n;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  lane_mask;

    int vectors    = 0;
    int miscompares = 0;

    // Press timing observations: edge of first mask change, edge of valid rise,
    // number of sampled cycles with word_valid high.
    int pm, pv, pc;

    // Reference model state.
    logic [7:0]  m_lane [4];
    logic [3:0]  m_mask;
    logic        m_offer;
    logic [31:0] m_word;

    switch_word_loader #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw         (sw),
        .key_n      (key_n),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .lane_mask  (lane_mask)
    );

    // Clock and reset block.
    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
        m_mask  = 4'h0;
        m_offer = 1'b0;
        m_word  = 32'h0;
    endfunction

    function automatic void m_press(input logic [9:0] s);
        if (!m_offer) begin
            m_lane[s[9:8]] = s[7:0];
            m_mask[s[9:8]] = 1'b1;
            if (m_mask == 4'hF) begin
                m_offer = 1'b1;
                m_word  = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
            end
        end
    endfunction

    function automatic void m_transfer();
        m_offer = 1'b0;
        m_mask  = 4'h0;
    endfunction

    // Driver: one clean press and release with sw set up 3 cycles ahead.
    task automatic press(input logic [9:0] s);
        logic [3:0] m0;
        logic       v0;
        @(negedge clk);
        sw = s;
        repeat (3) @(negedge clk);
        m0 = lane_mask;
        v0 = word_valid;
        pm = 0; pv = 0; pc = 0;
        key_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (pm == 0 && lane_mask !== m0) pm = k;
            if (pv == 0 && !v0 && word_valid === 1'b1) pv = k;
            if (word_valid === 1'b1) pc++;
            if (k == 10) key_n = 1'b1;
        end
    endtask

    // Driver: raise word_ready for one edge.
    task automatic do_transfer();
        @(negedge clk);
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        sw         = 10'($urandom_range(0, 1023));
        key_n      = 1'($urandom_range(0, 1));
        word_ready = 1'($urandom_range(0, 1));
        m_reset();
        #2;
        vectors++;
        if (word !== 32'h0 || word_valid !== 1'b0 || lane_mask !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_assert: word=%h valid=%b mask=%b, want 00000000/0/0", word, word_valid, lane_mask);
        end
        key_n = 1'b1;
        word_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (word !== 32'h0 || word_valid !== 1'b0 || lane_mask !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_idle: word=%h valid=%b mask=%b, want 00000000/0/0", word, word_valid, lane_mask);
        end
    endtask

    task automatic test_full_load();
        logic [9:0] d [4];
        logic [3:0] steps [4];
        d     = '{10'h021, 10'h143, 10'h265, 10'h387};
        steps = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            press(d[i]);
            m_press(d[i]);
            vectors++;
            if (lane_mask !== steps[i] || lane_mask !== m_mask) begin
                miscompares++;
                $display("FAIL full_mask[%0d]: got %b want %b", i, lane_mask, steps[i]);
            end
            vectors++;
            if (pm != DB + 3) begin
                miscompares++;
                $display("FAIL press_latency[%0d]: write at edge %0d, want %0d", i, pm, DB + 3);
            end
        end
        vectors++;
        if (pv != DB + 4) begin
            miscompares++;
            $display("FAIL offer_latency: valid rose at edge %0d, want %0d", pv, DB + 4);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (word_valid !== 1'b1 || word !== 32'h87654321) begin
            miscompares++;
            $display("FAIL full_hold: valid=%b word=%h, want 1/87654321", word_valid, word);
        end
        do_transfer();
        m_transfer();
        vectors++;
        if (word_valid !== 1'b0 || lane_mask !== 4'h0 || word !== 32'h87654321) begin
            miscompares++;
            $display("FAIL full_xfer: valid=%b mask=%b word=%h, want 0/0000/87654321", word_valid, lane_mask, word);
        end
    endtask

    task automatic test_bounce();
        @(negedge clk);
        sw = 10'h1AB;
        repeat (3) @(negedge clk);
        key_n = 1'b0;
        repeat (DB - 1) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        vectors++;
        if (lane_mask !== m_mask) begin
            miscompares++;
            $display("FAIL bounce_short: mask=%b want %b", lane_mask, m_mask);
        end
        key_n = 1'b0;
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        @(negedge clk);
        key_n = 1'b0;
        repeat (8) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
        m_press(10'h1AB);
        vectors++;
        if (lane_mask !== m_mask) begin
            miscompares++;
            $display("FAIL bounce_one: mask=%b want %b", lane_mask, m_mask);
        end
        // Clear the partial word before the next scenario.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
    endtask

    task automatic test_overwrite();
        logic [9:0] d [5];
        d = '{10'h011, 10'h0AA, 10'h1BB, 10'h2CC, 10'h3DD};
        for (int i = 0; i < 5; i++) begin
            press(d[i]);
            m_press(d[i]);
            if (i < 2) begin
                vectors++;
                if (lane_mask !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL overwrite_mask[%0d]: got %b want 0001", i, lane_mask);
                end
            end
        end
        vectors++;
        if (word_valid !== 1'b1 || word !== 32'hDDCCBBAA || word !== m_word) begin
            miscompares++;
            $display("FAIL overwrite_word: valid=%b word=%h want 1/ddccbbaa", word_valid, word);
        end
        do_transfer();
        m_transfer();
    endtask

    task automatic test_drop_during_offer();
        logic [9:0] s;
        for (int i = 0; i < 4; i++) begin
            s = {2'(i), 8'($urandom_range(0, 255))};
            press(s);
            m_press(s);
        end
        press(10'h0FF);
        m_press(10'h0FF);
        vectors++;
        if (word_valid !== 1'b1 || word !== m_word || lane_mask !== 4'hF) begin
            miscompares++;
            $display("FAIL drop_offer: valid=%b word=%h mask=%b want 1/%h/1111", word_valid, word, lane_mask, m_word);
        end
        do_transfer();
        m_transfer();
        for (int i = 3; i >= 0; i--) begin
            s = {2'(i), 8'($urandom_range(0, 255))};
            press(s);
            m_press(s);
        end
        vectors++;
        if (word_valid !== 1'b1 || word !== m_word) begin
            miscompares++;
            $display("FAIL drop_new_word: valid=%b word=%h want 1/%h", word_valid, word, m_word);
        end
        do_transfer();
        m_transfer();
    endtask

    task automatic test_ready_early();
        logic [9:0] s;
        for (int i = 0; i < 3; i++) begin
            s = {2'(i), 8'($urandom_range(0, 255))};
            press(s);
            m_press(s);
        end
        @(negedge clk);
        word_ready = 1'b1;
        s = {2'd3, 8'($urandom_range(0, 255))};
        press(s);
        m_press(s);
        m_transfer();
        word_ready = 1'b0;
        vectors++;
        if (pc != 1 || pv != DB + 4) begin
            miscompares++;
            $display("FAIL ready_early_pulse: valid cycles=%0d rise=%0d want 1/%0d", pc, pv, DB + 4);
        end
        vectors++;
        if (word !== m_word || word_valid !== 1'b0 || lane_mask !== 4'h0) begin
            miscompares++;
            $display("FAIL ready_early_state: word=%h valid=%b mask=%b want %h/0/0000", word, word_valid, lane_mask, m_word);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] s;
        press(10'h05A);
        m_press(10'h05A);
        press(10'h1C3);
        m_press(10'h1C3);
        vectors++;
        if (lane_mask !== 4'b0011) begin
            miscompares++;
            $display("FAIL reset_mid_pre: mask=%b want 0011", lane_mask);
        end
        @(negedge clk);
        reset_n = 1'b0;
        m_reset();
        #1;
        vectors++;
        if (lane_mask !== 4'h0 || word !== 32'h0 || word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: mask=%b word=%h valid=%b want 0/0/0", lane_mask, word, word_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = {2'(i), 8'($urandom_range(0, 255))};
            press(s);
            m_press(s);
        end
        vectors++;
        if (word_valid !== 1'b1 || word !== m_word) begin
            miscompares++;
            $display("FAIL reset_mid_after: valid=%b word=%h want 1/%h", word_valid, word, m_word);
        end
        do_transfer();
        m_transfer();
    endtask

    task automatic test_random();
        logic [9:0] s;
        for (int n = 0; n < 30; n++) begin
            s = 10'($urandom_range(0, 1023));
            press(s);
            m_press(s);
            vectors++;
            if (lane_mask !== m_mask || word_valid !== m_offer || word !== m_word) begin
                miscompares++;
                $display("FAIL random[%0d]: mask=%b valid=%b word=%h want %b/%b/%h",
                         n, lane_mask, word_valid, word, m_mask, m_offer, m_word);
            end
            if (m_offer && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                do_transfer();
                m_transfer();
                vectors++;
                if (lane_mask !== 4'h0 || word_valid !== 1'b0 || word !== m_word) begin
                    miscompares++;
                    $display("FAIL random_xfer[%0d]: mask=%b valid=%b word=%h want 0/0/%h",
                             n, lane_mask, word_valid, word, m_word);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_bounce();
        test_overwrite();
        test_drop_during_offer();
        test_ready_early();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
